// File: rtl/operand_sequencer.sv
// rtl/operand_sequencer.sv - two-operand capture sequencer feeding an external adder
module operand_sequencer #(
    parameter int NUM_BITS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [NUM_BITS-1:0] din,
    input  logic                       load,
    input  logic                       clear,
    input  logic                       acc_mode,
    output logic signed [NUM_BITS-1:0] a_out,
    output logic signed [NUM_BITS-1:0] b_out,
    input  logic signed [NUM_BITS-1:0] s_in,
    output logic signed [NUM_BITS-1:0] result,
    output logic                       z_q,
    output logic                       n_q,
    output logic                       p_q,
    output logic                       v_q,
    output logic                       done,
    output logic [1:0]                 state,
    output logic [3:0]                 op_count
);

    typedef enum logic [1:0] {
        WAIT_A  = 2'b00,
        WAIT_B  = 2'b01,
        CAPTURE = 2'b10,
        SHOW    = 2'b11
    } state_t;

    localparam int MSB = NUM_BITS - 1;

    state_t cur_state;
    state_t next_state;
    logic   load_q;
    logic   load_ev;

    // Button is a level; only its rising edge counts as a request.
    assign load_ev = load & ~load_q;
    assign done    = (cur_state == SHOW);
    assign state   = cur_state;

    always_comb begin
        next_state = cur_state;
        if (clear) begin
            next_state = WAIT_A;
        end else begin
            case (cur_state)
                WAIT_A:  if (load_ev) next_state = WAIT_B;
                WAIT_B:  if (load_ev) next_state = CAPTURE;
                CAPTURE: next_state = SHOW;
                SHOW:    if (load_ev) next_state = acc_mode ? CAPTURE : WAIT_B;
                default: next_state = WAIT_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= WAIT_A;
            load_q    <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
            result    <= '0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
            p_q       <= 1'b0;
            v_q       <= 1'b0;
            op_count  <= 4'd0;
        end else begin
            cur_state <= next_state;
            load_q    <= load;
            if (clear) begin
                a_out <= '0;
                b_out <= '0;
            end else begin
                case (cur_state)
                    WAIT_A: if (load_ev) a_out <= din;
                    WAIT_B: if (load_ev) b_out <= din;
                    CAPTURE: begin
                        result <= s_in;
                        z_q    <= (s_in == '0);
                        n_q    <= s_in[MSB];
                        p_q    <= ~s_in[0];
                        v_q    <= (a_out[MSB] == b_out[MSB]) && (s_in[MSB] != a_out[MSB]);
                        if (op_count != 4'd15) op_count <= op_count + 4'd1;
                    end
                    SHOW: begin
                        // Accumulate mode chains the shown result straight into A.
                        if (load_ev) begin
                            if (acc_mode) begin
                                a_out <= result;
                                b_out <= din;
                            end else begin
                                a_out <= din;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_operand_sequencer.sv
// tb/tb_operand_sequencer.sv - directed self-checking bench for operand_sequencer
module tb_operand_sequencer;

    logic              clk = 1'b0;
    logic              reset;
    logic signed [7:0] din;
    logic              load;
    logic              clear;
    logic              acc_mode;
    logic signed [7:0] a_out;
    logic signed [7:0] b_out;
    logic signed [7:0] s_in;
    logic signed [7:0] result;
    logic              z_q, n_q, p_q, v_q;
    logic              done;
    logic [1:0]        state;
    logic [3:0]        op_count;

    int checks = 0;
    int errors = 0;

    operand_sequencer #(.NUM_BITS(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .load     (load),
        .clear    (clear),
        .acc_mode (acc_mode),
        .a_out    (a_out),
        .b_out    (b_out),
        .s_in     (s_in),
        .result   (result),
        .z_q      (z_q),
        .n_q      (n_q),
        .p_q      (p_q),
        .v_q      (v_q),
        .done     (done),
        .state    (state),
        .op_count (op_count)
    );

    // Downstream adder, wrapping at 8 bits
    assign s_in = a_out + b_out;

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] v);
        din  = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; din = '0; load = 1'b0; clear = 1'b0; acc_mode = 1'b0;
        tick(2);
        reset = 1'b0;
        chk("rst_state", {6'd0, state}, 8'h00);
        chk("rst_a", a_out, 8'h00);
        chk("rst_b", b_out, 8'h00);
        chk("rst_result", result, 8'h00);
        chk("rst_flags", {4'd0, z_q, n_q, p_q, v_q}, 8'h00);
        chk("rst_done", {7'd0, done}, 8'h00);
        chk("rst_count", {4'd0, op_count}, 8'h00);

        // 5 + 3
        pulse(8'd5);
        chk("a5_state", {6'd0, state}, 8'h01);
        chk("a5_a", a_out, 8'h05);
        tick(1);
        pulse(8'd3);
        chk("cap_state", {6'd0, state}, 8'h02);
        chk("cap_done", {7'd0, done}, 8'h00);
        chk("cap_result_held", result, 8'h00);
        tick(1);
        chk("sum8_result", result, 8'h08);
        chk("sum8_flags", {4'd0, z_q, n_q, p_q, v_q}, 8'h02);
        chk("sum8_done", {7'd0, done}, 8'h01);
        chk("sum8_count", {4'd0, op_count}, 8'h01);

        // 127 + 1 overflow, entered from SHOW without accumulate
        pulse(8'd127);
        chk("show_new_a_state", {6'd0, state}, 8'h01);
        chk("show_new_a_result_held", result, 8'h08);
        tick(1);
        pulse(8'd1);
        tick(1);
        chk("ovf_result", result, 8'h80);
        chk("ovf_flags", {4'd0, z_q, n_q, p_q, v_q}, 8'h07);
        chk("ovf_count", {4'd0, op_count}, 8'h02);

        // -5 + 5 = 0
        pulse(8'hFB);
        tick(1);
        pulse(8'd5);
        tick(1);
        chk("zero_result", result, 8'h00);
        chk("zero_flags", {4'd0, z_q, n_q, p_q, v_q}, 8'h0A);

        // 10 + 20, then accumulate 7
        reset = 1'b1; tick(1); reset = 1'b0;
        pulse(8'd10);
        tick(1);
        pulse(8'd20);
        tick(1);
        chk("sum30_result", result, 8'h1E);
        acc_mode = 1'b1;
        tick(1);
        pulse(8'd7);
        chk("acc_a", a_out, 8'h1E);
        chk("acc_b", b_out, 8'h07);
        chk("acc_state", {6'd0, state}, 8'h02);
        tick(1);
        acc_mode = 1'b0;
        chk("acc_result", result, 8'h25);
        chk("acc_flags", {4'd0, z_q, n_q, p_q, v_q}, 8'h00);
        chk("acc_count", {4'd0, op_count}, 8'h02);
        tick(3);
        chk("show_hold_done", {7'd0, done}, 8'h01);
        chk("show_hold_result", result, 8'h25);

        // Clear from SHOW, then load held 5 cycles gives one event
        clear = 1'b1; tick(1); clear = 1'b0;
        chk("clr_state", {6'd0, state}, 8'h00);
        chk("clr_a", a_out, 8'h00);
        chk("clr_b", b_out, 8'h00);
        chk("clr_result_held", result, 8'h25);
        din = 8'd9; load = 1'b1;
        tick(5);
        din = 8'd4;
        tick(1);
        load = 1'b0;
        tick(1);
        chk("held_state", {6'd0, state}, 8'h01);
        chk("held_a", a_out, 8'h09);
        chk("held_b", b_out, 8'h00);
        clear = 1'b1; tick(1); clear = 1'b0;
        chk("clr_b_state", {6'd0, state}, 8'h00);
        chk("clr_b_a", a_out, 8'h00);
        chk("clr_b_result", result, 8'h25);
        chk("clr_b_count", {4'd0, op_count}, 8'h02);

        // Clear beats a same-cycle load event
        clear = 1'b1; din = 8'd6; load = 1'b1; tick(1);
        clear = 1'b0; load = 1'b0; tick(1);
        chk("clr_load_state", {6'd0, state}, 8'h00);
        chk("clr_load_a", a_out, 8'h00);

        // Reset during CAPTURE aborts the capture
        pulse(8'd2);
        tick(1);
        pulse(8'd3);
        chk("pre_rst_state", {6'd0, state}, 8'h02);
        reset = 1'b1; tick(1); reset = 1'b0;
        chk("cap_rst_state", {6'd0, state}, 8'h00);
        chk("cap_rst_result", result, 8'h00);
        chk("cap_rst_a", a_out, 8'h00);
        chk("cap_rst_b", b_out, 8'h00);
        chk("cap_rst_flags", {4'd0, z_q, n_q, p_q, v_q}, 8'h00);
        chk("cap_rst_done", {7'd0, done}, 8'h00);
        chk("cap_rst_count", {4'd0, op_count}, 8'h00);

        // Saturation of op_count
        for (int i = 0; i < 16; i++) begin
            pulse(8'd1);
            tick(1);
            pulse(8'd1);
            tick(2);
            if (i == 14) chk("count15", {4'd0, op_count}, 8'h0F);
        end
        chk("count_sat", {4'd0, op_count}, 8'h0F);
        chk("sat_result", result, 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
